fp_unpack_pipe: RTL and testbench



---
 rtl/fp_unpack_pkg.sv | 18 +
 rtl/fp_unpack_pipe_lzc.sv | 18 +
 rtl/fp_unpack_pipe.sv | 192 +++++++++++++++++++
 tb/tb_fp_unpack_pipe.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_unpack_pkg.sv
// Shared constants for the IEEE-754 unpack pipeline: class indices and common format widths.
package fp_unpack_pkg;

  localparam int unsigned CLS_ZERO   = 0;
  localparam int unsigned CLS_DENORM = 1;
  localparam int unsigned CLS_NORM   = 2;
  localparam int unsigned CLS_INF    = 3;
  localparam int unsigned CLS_NAN    = 4;
  localparam int unsigned NUM_CLS    = 5;

  localparam int unsigned FP16_EXP_W = 5;
  localparam int unsigned FP16_MAN_W = 10;
  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned FP64_EXP_W = 11;
  localparam int unsigned FP64_MAN_W = 52;

endpackage

// File: rtl/fp_unpack_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input yields W.
module fp_lzc #(
  parameter  int unsigned W  = 23,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] cnt_o
);

  // Scanning upward lets the highest set bit overwrite lower ones.
  always_comb begin
    cnt_o = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (data_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage IEEE-754 classifier/unpacker with valid/ready flow control.
// Optional per-class output counters are built when FP_UNPACK_STATS_EN is defined.
module fp_unpack_pipe
  import fp_unpack_pkg::*;
#(
  parameter int unsigned EXP_W = FP32_EXP_W,
  parameter int unsigned MAN_W = FP32_MAN_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [EXP_W+1:0]         out_exp,
  output logic [MAN_W:0]           out_mant,
  output logic [NUM_CLS-1:0]       out_class,
  output logic                     out_snan
`ifdef FP_UNPACK_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [NUM_CLS*CNT_W-1:0] stats_cnt
`endif
);

  localparam int unsigned LZ_W = $clog2(MAN_W + 1);
  localparam int unsigned XW   = EXP_W + 2;
  localparam logic [XW-1:0] BIAS = XW'((2 ** (EXP_W - 1)) - 1);

  if (MAN_W >= (2 ** EXP_W) || CNT_W == 0) begin : g_bad_params
    $error("fp_unpack_pipe: MAN_W must be below 2**EXP_W and CNT_W nonzero");
  end

  // Input field decode
  logic               in_sign;
  logic [EXP_W-1:0]   in_exp;
  logic [MAN_W-1:0]   in_frac;
  logic [NUM_CLS-1:0] in_class;
  logic [LZ_W-1:0]    in_lz;
  logic               exp_zero, exp_ones, frac_zero;

  assign {in_sign, in_exp, in_frac} = in_data;
  assign exp_zero  = ~|in_exp;
  assign exp_ones  = &in_exp;
  assign frac_zero = ~|in_frac;

  always_comb begin
    in_class = '0;
    if (exp_zero)      in_class[frac_zero ? CLS_ZERO : CLS_DENORM] = 1'b1;
    else if (exp_ones) in_class[frac_zero ? CLS_INF : CLS_NAN]     = 1'b1;
    else               in_class[CLS_NORM]                          = 1'b1;
  end

  fp_lzc #(
    .W(MAN_W)
  ) u_lzc (
    .data_i(in_frac),
    .cnt_o (in_lz)
  );

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv, s1_adv, accept;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)      s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Stage 1 data
  logic               s1_sign_q;
  logic [EXP_W-1:0]   s1_exp_q;
  logic [MAN_W-1:0]   s1_frac_q;
  logic [NUM_CLS-1:0] s1_class_q;
  logic [LZ_W-1:0]    s1_lz_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sign_q  <= in_sign;
      s1_exp_q   <= in_exp;
      s1_frac_q  <= in_frac;
      s1_class_q <= in_class;
      s1_lz_q    <= in_lz;
    end
  end

  // Stage 2 unpack
  logic [XW-1:0]   exp_d;
  logic [MAN_W:0]  mant_d;
  logic            snan_d;
  logic [LZ_W:0]   lz_p1;

  assign lz_p1 = {1'b0, s1_lz_q} + 1'b1;

  always_comb begin
    exp_d  = '0;
    mant_d = '0;
    snan_d = 1'b0;
    unique case (1'b1)
      s1_class_q[CLS_NORM]: begin
        exp_d  = XW'(s1_exp_q) - BIAS;
        mant_d = {1'b1, s1_frac_q};
      end
      s1_class_q[CLS_DENORM]: begin
        // 1 - BIAS - (lz + 1) folds to -BIAS - lz.
        exp_d  = '0 - BIAS - XW'(s1_lz_q);
        mant_d = {1'b0, s1_frac_q} << lz_p1;
      end
      s1_class_q[CLS_INF]: begin
        exp_d = BIAS + 1'b1;
      end
      s1_class_q[CLS_NAN]: begin
        exp_d  = BIAS + 1'b1;
        mant_d = {1'b0, s1_frac_q};
        snan_d = ~s1_frac_q[MAN_W-1];
      end
      s1_class_q[CLS_ZERO]: ;
      default: ;
    endcase
  end

  logic               out_sign_q;
  logic [XW-1:0]      out_exp_q;
  logic [MAN_W:0]     out_mant_q;
  logic [NUM_CLS-1:0] out_class_q;
  logic               out_snan_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_mant_q  <= '0;
      out_class_q <= '0;
      out_snan_q  <= 1'b0;
    end else if (s1_adv) begin
      out_sign_q  <= s1_sign_q;
      out_exp_q   <= exp_d;
      out_mant_q  <= mant_d;
      out_class_q <= s1_class_q;
      out_snan_q  <= snan_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_mant  = out_mant_q;
  assign out_class = out_class_q;
  assign out_snan  = out_snan_q;

`ifdef FP_UNPACK_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_CLS];

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      for (int unsigned i = 0; i < NUM_CLS; i++) cnt_q[i] <= '0;
    end else if (s2_valid_q && out_ready) begin
      for (int unsigned i = 0; i < NUM_CLS; i++) begin
        if (out_class_q[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stats_cnt = '0;
    for (int unsigned i = 0; i < NUM_CLS; i++) stats_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed bench for fp_unpack_pipe: FP32 and FP16 instances, stats checks when enabled.
module tb_fp_unpack_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic stats_clr;

  // FP32 instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sign, a_snan;
  logic [31:0] a_in_data;
  logic [9:0]  a_exp;
  logic [23:0] a_mant;
  logic [4:0]  a_class;
  logic [9:0]  a_stats_cnt;

  fp_unpack_pipe #(
    .EXP_W(8),
    .MAN_W(23),
    .CNT_W(2)
  ) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .in_data  (a_in_data),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .out_sign (a_sign),
    .out_exp  (a_exp),
    .out_mant (a_mant),
    .out_class(a_class),
    .out_snan (a_snan)
`ifdef FP_UNPACK_STATS_EN
    ,
    .stats_clr(stats_clr),
    .stats_cnt(a_stats_cnt)
`endif
  );

  // FP16 instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sign, b_snan;
  logic [15:0] b_in_data;
  logic [6:0]  b_exp;
  logic [10:0] b_mant;
  logic [4:0]  b_class;
  logic [79:0] b_stats_cnt;
  logic        b_stats_clr;

  fp_unpack_pipe #(
    .EXP_W(5),
    .MAN_W(10)
  ) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .in_data  (b_in_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .out_sign (b_sign),
    .out_exp  (b_exp),
    .out_mant (b_mant),
    .out_class(b_class),
    .out_snan (b_snan)
`ifdef FP_UNPACK_STATS_EN
    ,
    .stats_clr(b_stats_clr),
    .stats_cnt(b_stats_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] mant;
    logic [4:0]  cls;
    logic        snan;
    logic        v;
    logic        rdy;
    logic        ir;
    int          cyc;
  } rec_t;

  rec_t        cap[$];
  rec_t        tr[$];
  logic [31:0] stim[$];
  int          stall_lo, stall_hi;

  function automatic logic [40:0] pk(input rec_t r);
    return {r.sign, r.exp, r.mant, r.cls, r.snan};
  endfunction

  // Drives stim into the FP32 instance, tracing every cycle and capturing output transfers.
  task automatic run_a();
    int   i   = 0;
    int   cyc = 0;
    rec_t r;
    cap.delete();
    tr.delete();
    while ((i < stim.size() || cap.size() < stim.size()) && cyc < 100) begin
      @(negedge clk);
      a_in_valid  = (i < stim.size());
      a_in_data   = '0;
      if (i < stim.size()) a_in_data = stim[i];
      a_out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      #2;
      r.sign = a_sign; r.exp = a_exp; r.mant = a_mant; r.cls = a_class; r.snan = a_snan;
      r.v = a_out_valid; r.rdy = a_out_ready; r.ir = a_in_ready; r.cyc = cyc;
      tr.push_back(r);
      if (a_in_valid && a_in_ready) i++;
      if (a_out_valid && a_out_ready) cap.push_back(r);
      cyc++;
    end
    @(negedge clk);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #2;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
    checks++;
    if ({a_sign, a_exp, a_mant, a_class, a_snan} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {a_sign, a_exp, a_mant, a_class, a_snan});
    end
    checks++;
    if ({b_out_valid, b_in_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_fp16: got %b want 01", {b_out_valid, b_in_ready});
    end
  endtask

  task automatic test_fp32_basic();
    logic [40:0] want [3];
    want[0] = {1'b0, 10'd0, 24'h800000, 5'b00100, 1'b0};
    want[1] = {1'b0, 10'(-149), 24'h800000, 5'b00010, 1'b0};
    want[2] = {1'b1, 10'd0, 24'h000000, 5'b00001, 1'b0};
    stim = '{32'h3F800000, 32'h00000001, 32'h80000000};
    stall_lo = 0; stall_hi = 0;
    run_a();
    checks++;
    if (cap.size() != 3) begin
      errors++; $display("FAIL basic_count: got %0d want 3", cap.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (pk(cap[k]) !== want[k]) begin
          errors++; $display("FAIL basic_word%0d: got %h want %h", k, pk(cap[k]), want[k]);
        end
        checks++;
        if (cap[k].cyc != k + 2) begin
          errors++; $display("FAIL basic_latency%0d: got cycle %0d want %0d", k, cap[k].cyc, k + 2);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [40:0] want [3];
    want[0] = {1'b0, 10'd128, 24'h000000, 5'b01000, 1'b0};
    want[1] = {1'b0, 10'd128, 24'h400000, 5'b10000, 1'b0};
    want[2] = {1'b0, 10'd128, 24'h000001, 5'b10000, 1'b1};
    stim = '{32'h7F800000, 32'h7FC00000, 32'h7F800001};
    stall_lo = 0; stall_hi = 0;
    run_a();
    checks++;
    if (cap.size() != 3) begin
      errors++; $display("FAIL special_count: got %0d want 3", cap.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (pk(cap[k]) !== want[k]) begin
          errors++; $display("FAIL special_word%0d: got %h want %h", k, pk(cap[k]), want[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [40:0] want [8];
    int held = 0;
    int unstable = 0;
    int ir_low = 0;
    want[0] = {1'b0, 10'd0, 24'h800000, 5'b00100, 1'b0};
    want[1] = {1'b0, 10'd1, 24'h800000, 5'b00100, 1'b0};
    want[2] = {1'b0, 10'd1, 24'hC00000, 5'b00100, 1'b0};
    want[3] = {1'b0, 10'(-148), 24'h800000, 5'b00010, 1'b0};
    want[4] = {1'b1, 10'd0, 24'h800000, 5'b00100, 1'b0};
    want[5] = {1'b0, 10'(-1), 24'h800000, 5'b00100, 1'b0};
    want[6] = {1'b0, 10'(-127), 24'h800000, 5'b00010, 1'b0};
    want[7] = {1'b0, 10'd2, 24'h800000, 5'b00100, 1'b0};
    stim = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h00000002,
             32'hBF800000, 32'h3F000000, 32'h00400000, 32'h40800000};
    stall_lo = 3; stall_hi = 8;
    run_a();
    checks++;
    if (cap.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d want 8", cap.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (pk(cap[k]) !== want[k]) begin
          errors++; $display("FAIL b2b_word%0d: got %h want %h", k, pk(cap[k]), want[k]);
        end
      end
    end
    for (int c = 0; c < tr.size(); c++) begin
      if (!tr[c].ir) ir_low++;
      if (c > 0 && tr[c-1].v && !tr[c-1].rdy) begin
        held++;
        if (!tr[c].v || pk(tr[c]) !== pk(tr[c-1])) unstable++;
      end
    end
    checks++;
    if (ir_low != 5) begin
      errors++; $display("FAIL b2b_in_ready_low: got %0d cycles want 5", ir_low);
    end
    checks++;
    if (held != 5) begin
      errors++; $display("FAIL b2b_stalled_cycles: got %0d want 5", held);
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL b2b_stall_stable: got %0d changed cycles want 0", unstable);
    end
  endtask

  task automatic test_fp16();
    logic [15:0] words [3];
    logic [24:0] want  [3];
    logic [24:0] got[$];
    int          gcyc[$];
    words[0] = 16'h0001; words[1] = 16'h3C00; words[2] = 16'h7BFF;
    want[0] = {1'b0, 7'(-24), 11'h400, 5'b00010, 1'b0};
    want[1] = {1'b0, 7'd0, 11'h400, 5'b00100, 1'b0};
    want[2] = {1'b0, 7'd15, 11'h7FF, 5'b00100, 1'b0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      b_in_valid  = (c < 3);
      b_in_data   = (c < 3) ? words[c] : 16'h0000;
      b_out_ready = 1'b1;
      #2;
      if (b_out_valid && b_out_ready) begin
        got.push_back({b_sign, b_exp, b_mant, b_class, b_snan});
        gcyc.push_back(c);
      end
    end
    b_in_valid = 1'b0;
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL fp16_count: got %0d want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== want[k] || gcyc[k] != k + 2) begin
          errors++;
          $display("FAIL fp16_word%0d: got %h at cycle %0d want %h at cycle %0d",
                   k, got[k], gcyc[k], want[k], k + 2);
        end
      end
    end
  endtask

  task automatic test_reset_full();
    int seen = 0;
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h3F800000;
    @(negedge clk);
    a_in_data = 32'h40000000;
    @(negedge clk);
    a_in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_full_pre: got %b want 10", {a_out_valid, a_in_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    a_out_ready = 1'b1;
    #2;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      errors++; $display("FAIL rst_full_post: got %b want 01", {a_out_valid, a_in_ready});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #2;
      if (a_out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_full_drop: got %0d outputs want 0", seen);
    end
  endtask

`ifdef FP_UNPACK_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #2;
    checks++;
    if (a_stats_cnt !== 10'h000) begin
      errors++; $display("FAIL stats_clear: got %h want 000", a_stats_cnt);
    end
    stim = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000};
    stall_lo = 0; stall_hi = 0;
    run_a();
    #2;
    checks++;
    if (a_stats_cnt !== 10'h300) begin
      errors++; $display("FAIL stats_nan_sat: got %h want 300", a_stats_cnt);
    end
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 32'h3F800000;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    stats_clr = 1'b1;
    #2;
    checks++;
    if (a_out_valid !== 1'b1) begin
      errors++; $display("FAIL stats_clr_pre: got out_valid %b want 1", a_out_valid);
    end
    @(negedge clk);
    stats_clr = 1'b0;
    #2;
    checks++;
    if (a_stats_cnt !== 10'h000) begin
      errors++; $display("FAIL stats_clr_priority: got %h want 000", a_stats_cnt);
    end
    checks++;
    if (b_stats_cnt !== 80'h0) begin
      errors++; $display("FAIL stats_fp16_idle: got %h want 0", b_stats_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stats_clr = 1'b0; b_stats_clr = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    stall_lo = 0; stall_hi = 0;
    test_reset();
    test_fp32_basic();
    test_special();
    test_back_to_back();
    test_fp16();
    test_reset_full();
`ifdef FP_UNPACK_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
